if_stage: RTL and testbench

//  Instruction-fetch stage of the 16-bit pipelined core, directly upstream of decode.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/if_id_reg.sv | 48 ++++
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and IF-stage state encoding for the 16-bit pipelined core.
package cpu_pkg;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] PC_INC   = 16'd2;
    localparam logic [15:0] NOP_IR   = 16'h0000;

    typedef enum logic [1:0] {
        ST_REQ   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched instruction, insert a bubble, or hold.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [15:0] BUBBLE_IR = NOP_IR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_load,
    input  logic        i_bubble,
    input  logic [15:0] i_pc,
    input  logic [15:0] i_pc2,
    input  logic [15:0] i_ir,
    output logic [15:0] o_pc,
    output logic [15:0] o_pc2,
    output logic [15:0] o_ir,
    output logic        o_valid
);

    logic [15:0] r_pc;
    logic [15:0] r_pc2;
    logic [15:0] r_ir;
    logic        r_valid;

    // A bubble keeps the pc fields so decode still sees the last real PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= 16'h0000;
            r_pc2   <= 16'h0000;
            r_ir    <= BUBBLE_IR;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_pc    <= i_pc;
            r_pc2   <= i_pc2;
            r_ir    <= i_ir;
            r_valid <= 1'b1;
        end else if (i_bubble) begin
            r_ir    <= BUBBLE_IR;
            r_valid <= 1'b0;
        end
    end

    assign o_pc    = r_pc;
    assign o_pc2   = r_pc2;
    assign o_ir    = r_ir;
    assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, single-outstanding imem handshake FSM, hold buffer and IF/ID register.
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC_P = RESET_PC,
    parameter logic [15:0] PC_INC_P   = PC_INC,
    parameter logic [15:0] NOP_IR_P   = NOP_IR
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_rdata,
    input  logic        imem_valid,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic [15:0] pc_out,
    output logic [15:0] pc2_out,
    output logic [15:0] IR_out,
    output logic        valid_out
);

    if_state_t   r_state;
    if_state_t   w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] w_pc_nxt;
    logic [15:0] r_buf_ir;
    logic [15:0] w_buf_ir_nxt;
    logic [15:0] w_pc_inc;
    logic        w_load;
    logic        w_bubble;
    logic [15:0] w_load_ir;

    assign w_pc_inc  = r_pc + PC_INC_P;
    assign imem_req  = (r_state == ST_REQ);
    assign imem_addr = r_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_REQ;
            r_pc     <= RESET_PC_P;
            r_buf_ir <= NOP_IR_P;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_buf_ir <= w_buf_ir_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_pc_nxt     = r_pc;
        w_buf_ir_nxt = r_buf_ir;
        w_load       = 1'b0;
        w_bubble     = 1'b0;
        w_load_ir    = imem_rdata;
        if (redirect) begin
            // An issued request cannot be cancelled, so its late response must be drained.
            w_pc_nxt     = redirect_pc;
            w_bubble     = 1'b1;
            w_buf_ir_nxt = NOP_IR_P;
            unique case (r_state)
                ST_REQ:   w_state_nxt = imem_valid ? ST_REQ : ST_DRAIN;
                ST_HOLD:  w_state_nxt = ST_REQ;
                ST_DRAIN: w_state_nxt = imem_valid ? ST_REQ : ST_DRAIN;
                default:  w_state_nxt = ST_REQ;
            endcase
        end else begin
            unique case (r_state)
                ST_REQ: begin
                    if (imem_valid && !stall) begin
                        w_load   = 1'b1;
                        w_pc_nxt = w_pc_inc;
                    end else if (imem_valid) begin
                        w_buf_ir_nxt = imem_rdata;
                        w_state_nxt  = ST_HOLD;
                    end else begin
                        w_bubble = !stall;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        w_load       = 1'b1;
                        w_load_ir    = r_buf_ir;
                        w_pc_nxt     = w_pc_inc;
                        w_buf_ir_nxt = NOP_IR_P;
                        w_state_nxt  = ST_REQ;
                    end
                end
                ST_DRAIN: begin
                    w_bubble = !stall;
                    if (imem_valid) begin
                        w_state_nxt = ST_REQ;
                    end
                end
                default: w_state_nxt = ST_REQ;
            endcase
        end
    end

    if_id_reg #(
        .BUBBLE_IR(NOP_IR_P)
    ) u_if_id_reg (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_load),
        .i_bubble (w_bubble),
        .i_pc     (r_pc),
        .i_pc2    (w_pc_inc),
        .i_ir     (w_load_ir),
        .o_pc     (pc_out),
        .o_pc2    (pc2_out),
        .o_ir     (IR_out),
        .o_valid  (valid_out)
    );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: zero-wait fetch, latency bubble, stall/HOLD, redirect/DRAIN, wrap, async reset.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_valid;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] pc_out;
    logic [15:0] pc2_out;
    logic [15:0] IR_out;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    if_stage dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .imem_valid  (imem_valid),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc_out      (pc_out),
        .pc2_out     (pc2_out),
        .IR_out      (IR_out),
        .valid_out   (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] pc, input logic [15:0] pc2,
                            input logic [15:0] ir, input logic vld);
        chk({tag, ".pc_out"}, pc_out, pc);
        chk({tag, ".pc2_out"}, pc2_out, pc2);
        chk({tag, ".IR_out"}, IR_out, ir);
        chk({tag, ".valid_out"}, {15'h0, valid_out}, {15'h0, vld});
    endtask

    task automatic chk_mem(input string tag, input logic req, input logic [15:0] addr);
        chk({tag, ".imem_req"}, {15'h0, imem_req}, {15'h0, req});
        if (req) chk({tag, ".imem_addr"}, imem_addr, addr);
    endtask

    initial begin
        rst         = 1'b1;
        imem_rdata  = 16'h0000;
        imem_valid  = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 16'h0000;
        #3;
        chk_ifid("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        #9;
        rst = 1'b0;
        #1;
        chk_mem("post_reset", 1'b1, 16'h0000);

        // Zero-wait memory: one instruction per cycle.
        imem_valid = 1'b1; imem_rdata = 16'h1234;
        cyc();
        chk_ifid("zw0", 16'h0000, 16'h0002, 16'h1234, 1'b1);
        chk_mem("zw0", 1'b1, 16'h0002);
        imem_rdata = 16'h5678;
        cyc();
        chk_ifid("zw1", 16'h0002, 16'h0004, 16'h5678, 1'b1);
        chk_mem("zw1", 1'b1, 16'h0004);

        // Stall three cycles while A001 arrives for pc 0004.
        imem_rdata = 16'hA001; stall = 1'b1;
        cyc();
        chk_ifid("stall1", 16'h0002, 16'h0004, 16'h5678, 1'b1);
        chk_mem("stall1", 1'b0, 16'h0000);
        imem_valid = 1'b0; imem_rdata = 16'h0000;
        cyc();
        chk_ifid("stall2", 16'h0002, 16'h0004, 16'h5678, 1'b1);
        chk_mem("stall2", 1'b0, 16'h0000);
        cyc();
        chk_ifid("stall3", 16'h0002, 16'h0004, 16'h5678, 1'b1);
        stall = 1'b0;
        cyc();
        chk_ifid("unstall", 16'h0004, 16'h0006, 16'hA001, 1'b1);
        chk_mem("unstall", 1'b1, 16'h0006);

        // Two-cycle latency: one bubble, address held.
        cyc();
        chk_ifid("lat_bubble", 16'h0004, 16'h0006, 16'h0000, 1'b0);
        chk_mem("lat_bubble", 1'b1, 16'h0006);
        imem_valid = 1'b1; imem_rdata = 16'hB006;
        cyc();
        chk_ifid("lat_word", 16'h0006, 16'h0008, 16'hB006, 1'b1);
        chk_mem("lat_word", 1'b1, 16'h0008);

        // Redirect while request to 0008 is outstanding.
        imem_valid = 1'b0; redirect = 1'b1; redirect_pc = 16'h0040;
        cyc();
        chk_ifid("redir", 16'h0006, 16'h0008, 16'h0000, 1'b0);
        chk_mem("redir_drain", 1'b0, 16'h0000);
        chk("redir_addr", imem_addr, 16'h0040);
        redirect = 1'b0; imem_valid = 1'b1; imem_rdata = 16'hDEAD;
        cyc();
        chk_ifid("drain", 16'h0006, 16'h0008, 16'h0000, 1'b0);
        chk_mem("drain", 1'b1, 16'h0040);
        imem_rdata = 16'hC040;
        cyc();
        chk_ifid("at40", 16'h0040, 16'h0042, 16'hC040, 1'b1);
        chk_mem("at40", 1'b1, 16'h0042);

        // Redirect together with stall while in HOLD; buffered D042 is dropped.
        imem_rdata = 16'hD042; stall = 1'b1;
        cyc();
        chk_ifid("hold", 16'h0040, 16'h0042, 16'hC040, 1'b1);
        chk_mem("hold", 1'b0, 16'h0000);
        imem_valid = 1'b0; redirect = 1'b1; redirect_pc = 16'hFFFE;
        cyc();
        chk_ifid("hold_redir", 16'h0040, 16'h0042, 16'h0000, 1'b0);
        chk_mem("hold_redir", 1'b1, 16'hFFFE);

        // Fetch at FFFE wraps pc2 and next address to 0000.
        redirect = 1'b0; stall = 1'b0; imem_valid = 1'b1; imem_rdata = 16'hE0FE;
        cyc();
        chk_ifid("wrap", 16'hFFFE, 16'h0000, 16'hE0FE, 1'b1);
        chk_mem("wrap", 1'b1, 16'h0000);

        // Async reset pulse mid-wait.
        imem_valid = 1'b0;
        cyc();
        chk_ifid("wait_bubble", 16'hFFFE, 16'h0000, 16'h0000, 1'b0);
        chk_mem("wait_bubble", 1'b1, 16'h0000);
        imem_valid = 1'b1; imem_rdata = 16'h7777;
        cyc();
        imem_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_ifid("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        chk_mem("async_rst", 1'b1, 16'h0000);
        #1;
        rst = 1'b0;
        cyc();
        chk_ifid("after_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
        chk_mem("after_rst", 1'b1, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
